corescore_collector: RTL and testbench

//  Receive end of the CoreScore UART link. Deserialises 8N1 UART frames from i_uart_rx and

---
 rtl/corescore_uart_pkg.sv | 13 +
 rtl/corescore_stream_fifo.sv | 43 ++++
 rtl/corescore_collector.sv | 106 ++++++++++
 tb/tb_corescore_collector.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/corescore_uart_pkg.sv
// corescore_uart_pkg: shared UART state encodings, framing constants and bit-period helper
package corescore_uart_pkg;

    typedef enum logic [2:0] {ST_ARM, ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam logic [7:0] DEFAULT_EOL_CHAR = 8'h0A;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/corescore_stream_fifo.sv
// corescore_stream_fifo: first-word-fall-through FIFO with full-FIFO push accepted when a pop coincides
module corescore_stream_fifo #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       cnt_q;
    logic              do_push, do_pop;

    assign o_empty = cnt_q == '0;
    assign o_full  = cnt_q == (AW+1)'(DEPTH);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_data  = mem_q[rd_q];

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= i_data;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end

endmodule

// File: rtl/corescore_collector.sv
// corescore_collector: 8N1 UART receiver presenting each byte as an AXI4-Stream beat, tlast on EOL
module corescore_collector
    import corescore_uart_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 16_000_000,
    parameter int         BAUD_RATE   = 57_600,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] EOL_CHAR    = DEFAULT_EOL_CHAR
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int DW  = $clog2(DIV + 1);
    localparam logic [DW-1:0] DIV_END = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_MID = DW'(DIV / 2 - 1);

    if (DIV < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("corescore_collector: DIV must be >= 4 and FIFO_DEPTH a power of 2 >= 2");
    end

    uart_state_e state_q;
    logic [1:0]    sync_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          frame_err_q, overrun_q;
    logic          rxs, div_end, push, full, empty;
    logic [8:0]    head;

    assign rxs         = sync_q[1];
    assign div_end     = div_q == DIV_END;
    assign push        = state_q == ST_STOP && div_end && rxs;
    assign o_tvalid    = !empty;
    assign {o_tlast, o_tdata} = head;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

    // The stop bit's second half is not waited out so the next start edge is caught at once.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state_q     <= ST_ARM;
            sync_q      <= 2'b11;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], i_uart_rx};
            frame_err_q <= 1'b0;
            overrun_q   <= push && full && !i_tready;
            div_q       <= div_q + 1'b1;
            case (state_q)
                ST_ARM:
                    if (!rxs) div_q <= '0;
                    else if (div_end) begin
                        div_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                ST_IDLE: begin
                    div_q <= '0;
                    if (!rxs) state_q <= ST_START;
                end
                ST_START:
                    if (div_q == DIV_MID) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rxs ? ST_IDLE : ST_DATA;
                    end
                ST_DATA:
                    if (div_end) begin
                        div_q   <= '0;
                        shift_q <= {rxs, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'(UART_DATA_BITS - 1)) state_q <= ST_STOP;
                    end
                ST_STOP:
                    if (div_end) begin
                        div_q       <= '0;
                        frame_err_q <= !rxs;
                        state_q     <= rxs ? ST_IDLE : ST_ARM;
                    end
                default: state_q <= ST_ARM;
            endcase
        end

    corescore_stream_fifo #(.DATA_W(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  ({shift_q == EOL_CHAR, shift_q}),
        .o_full  (full),
        .i_pop   (i_tready),
        .o_data  (head),
        .o_empty (empty)
    );

endmodule

// File: tb/tb_corescore_collector.sv
// tb_corescore_collector: frame-level scoreboard bench for the UART-to-AXIS collector
module tb_corescore_collector;
    localparam int         DIV   = 16;
    localparam int         DEPTH = 4;
    localparam logic [7:0] EOL   = 8'h0A;

    logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, tready = 1'b0;
    logic [7:0] o_tdata;
    logic       o_tlast, o_tvalid, o_frame_err, o_overrun;

    int pass_cnt = 0, chk_cnt = 0;
    int cyc = 0, last_start = 0, rise_cyc = -1, rmode = 0;
    int beats = 0, ferr_seen = 0, ovr_seen = 0, exp_ferr = 0, exp_ovr = 0;
    int b0, f0, o0;
    logic [8:0] exp_q[$];
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [8:0] prev_d = '0;

    corescore_collector #(
        .CLK_FREQ_HZ (1_600_000),
        .BAUD_RATE   (100_000),
        .FIFO_DEPTH  (DEPTH),
        .EOL_CHAR    (EOL)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_uart_rx   (rx),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .i_tready    (tready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame-level model: a good frame lands in the buffer unless it already holds DEPTH bytes.
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) exp_ferr++;
        else if (exp_q.size() < DEPTH) exp_q.push_back({b == EOL, b});
        else exp_ovr++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        last_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            if (i == 9) model_frame(b, stop);
            tick(DIV);
        end
        rx = 1'b1;
        tick(gap);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
        check("drain_empty", exp_q.size(), 0);
        tick(4);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        tready = rmode == 0 ? 1'b0 : rmode == 1 ? 1'b1 : rmode == 2 ? (cyc % 3 == 0) : ($urandom_range(3) != 0);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {o_tdata, o_tlast, o_tvalid, o_frame_err, o_overrun}, 0);
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_valid", o_tvalid, 1);
                check("hold_data", {o_tlast, o_tdata}, prev_d);
            end
            if (o_tvalid && !prev_v) rise_cyc = cyc;
            if (o_tvalid) check("tlast_rule", o_tlast, o_tdata == EOL);
            if (o_tvalid && tready) begin
                beats++;
                if (exp_q.size() == 0) check("beat_expected", 0, 1);
                else check("beat", {o_tlast, o_tdata}, exp_q.pop_front());
            end
            ferr_seen += o_frame_err;
            ovr_seen  += o_overrun;
            prev_v = o_tvalid;
            prev_r = tready;
            prev_d = {o_tlast, o_tdata};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(30);
        rmode = 1;
        b0 = beats;
        send_byte(8'h41, 1'b1, 4);
        drain();
        check("t1_beats", beats - b0, 1);
        check("t1_latency", rise_cyc, last_start + 155);
        check("t1_no_err", ferr_seen + ovr_seen, 0);

        rmode = 2;
        b0 = beats;
        send_byte(8'h4F, 1'b1, 0);
        send_byte(8'h4B, 1'b1, 0);
        send_byte(8'h0A, 1'b1, 4);
        drain();
        check("t2_beats", beats - b0, 3);

        rmode = 1;
        b0 = beats;
        f0 = ferr_seen;
        send_byte(8'h55, 1'b0, 16);
        send_byte(8'h33, 1'b1, 4);
        drain();
        check("t3_frame_err", ferr_seen - f0, 1);
        check("t3_beats", beats - b0, 1);

        rmode = 0;
        tick(2);
        b0 = beats;
        o0 = ovr_seen;
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1, 2);
        tick(4);
        check("t4_overruns", ovr_seen - o0, 2);
        check("t4_stalled", beats - b0, 0);
        rmode = 1;
        drain();
        check("t4_beats", beats - b0, 4);

        b0 = beats;
        f0 = ferr_seen;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(40);
        check("t5_no_beat", beats - b0, 0);
        check("t5_no_err", ferr_seen - f0, 0);
        send_byte(8'h7E, 1'b1, 4);
        drain();
        check("t5_recovers", beats - b0, 1);

        b0 = beats;
        begin
            logic [9:0] fr;
            fr = {1'b1, 8'hA5, 1'b0};
            for (int i = 0; i < 10; i++) begin
                rx = fr[i];
                if (i == 3) begin
                    tick(5);
                    rst_n = 1'b0;
                    tick(11);
                end else if (i == 6) begin
                    tick(6);
                    rst_n = 1'b1;
                    tick(10);
                end else tick(DIV);
            end
        end
        rx = 1'b1;
        tick(20);
        check("t6_no_spurious", beats - b0, 0);
        send_byte(8'h5A, 1'b1, 4);
        drain();
        check("t6_beats", beats - b0, 1);

        rmode = 3;
        for (int i = 0; i < 20; i++) begin
            logic st;
            st = $urandom_range(5) != 0;
            send_byte(8'($urandom_range(255)), st, st ? $urandom_range(4) : DIV + $urandom_range(4));
        end
        drain();
        check("frame_err_total", ferr_seen, exp_ferr);
        check("overrun_total", ovr_seen, exp_ovr);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
